output_harness_multi: RTL and testbench
=======================================

# output_harness_multi

Multi-channel successor to the single-pin synthesis output harness. It compresses CHANNELS independent BITS-wide buses in the fast_clk domain into per-channel DIGEST-bit XOR signatures, accumulating only on valid cycles. The full signature word crosses to slow_clk through a toggle request/acknowledge handshake and is shifted out serially on one pin with a frame marker. It sits at the top of synthesis-only wrappers so that every data bit stays live, and a slow logic analyser can read a coherent digest.

## Interface
- BITS, 64, per-channel data width; power of 2, ≥2
- CHANNELS, 4, number of input buses; ≥1
- DIGEST, 8, per-channel signature width; power of 2, ≤BITS
- SYNC_STAGES, 3, synchroniser depth for each crossing; ≥2
- fast_clk  in  1  source-domain clock
- slow_clk  in  1  output-domain clock; unrelated to fast_clk
- rst_n  in  1  reset, synchronous, active-low; sampled independently in each domain
- data_on_fast_clk  in  CHANNELS*BITS  channel c occupies bits [c*BITS +: BITS]
- valid_on_fast_clk  in  CHANNELS  per-channel accumulate enable
- pin_on_slow_clk  out  1  serial signature bit
- frame_on_slow_clk  out  1  high during the first bit of each frame

## Operation
- Fast pipeline, per channel: input registers data_reg/valid_reg; acc ← acc ^ data_reg when valid_reg, else hold.
- Fold: L = log2(BITS/DIGEST) registered stages, each computing low half ^ high half. When L=0, the signature is acc itself.
- Signature sig (FRAME = CHANNELS*DIGEST bits) = concatenation of the channel digests, with channel 0 in the LSBs.
- Fast FSM has two states, IDLE and WAIT.
  - IDLE: when req == ack_sync, latch sig into hold, toggle req, go to WAIT.
  - WAIT: when ack_sync == req, return to IDLE.
  - hold is stable in WAIT and is never written there.
- Slow FSM has two states, IDLE and SHIFT.
  - IDLE: when req_sync != req_seen, load shifter ← hold, set req_seen ← req_sync, toggle ack, set cnt ← 0, go to SHIFT.
  - SHIFT: pin = shifter[0]; shift right once per slow cycle; frame = (cnt==0); after bit FRAME-1, return to IDLE.
  - A request arriving during SHIFT waits until IDLE. No frame is dropped or truncated.
- In IDLE, pin = 0 and frame = 0.
- Reset values: all accumulators, fold stages, hold, req, ack, synchronisers, shifter and counters are 0. pin_on_slow_clk = 0, frame_on_slow_clk = 0, and both FSMs are in IDLE.
- rst_n must be held for ≥ SYNC_STAGES+2 cycles of the slower clock. Reset mid-frame aborts the frame, and the outputs are 0 from the first slow edge with rst_n low.

## Timing
- Data sampled at fast edge t reaches acc at t+2 and sig at t+2+L.
- Capture happens only in IDLE. A sig change during WAIT is reported in the next frame.
- req is seen on the slow side after SYNC_STAGES slow edges. The shifter loads one edge later, and the first bit (frame=1) is driven from that edge.
- The ack round trip is SYNC_STAGES fast edges. Frames are therefore separated by at least one IDLE slow cycle.
- Frame length is exactly FRAME slow cycles, LSB first.
- Counter width is clog2(FRAME) bits, with no wrap inside a frame.

## Structure
- Package output_harness_pkg holds:
  - the fold-stage count function
  - the FRAME width function
  - enum types for the fast states (IDLE/WAIT) and slow states (IDLE/SHIFT)
- Sub-module toggle_sync (parameter SYNC_STAGES, reset to 0) is used for both the req and ack crossings.
- Fold stages are built in a generate loop, with one register array per stage.

## Test plan
- BITS=8, CHANNELS=2, DIGEST=4. Drive one valid cycle of ch0=0x0F and ch1=0x30 → a frame with sig 0x3F, pin sequence 1,1,1,1,1,1,0,0, frame high on bit 0 only.
- Same configuration, ch0=0xFF with valid low for 100 cycles → every frame reads 0x00.
- Drive 0x0F twice on ch0 with valid → acc cancels and the next frames read 0x00. Check that no partial (mixed) frame ever appears.
- Change the input every fast cycle with a 7:1 fast/slow ratio → each frame equals some captured sig (checked against the model at capture time), and frames are never overlapped or cut short.
- Assert rst_n mid-frame (bit 3) for SYNC_STAGES+2 slow cycles → pin/frame go 0 at once; the first frame after release reads 0x00.
- DIGEST=BITS=8, CHANNELS=1, ch0=0xA5 valid → frame pin sequence 1,0,1,0,0,1,0,1 with no fold latency (sig at t+2).

Source files
------------

// File: rtl/output_harness_pkg.sv
// Shared elaboration helpers and FSM state types for the multi-channel output harness.
package output_harness_pkg;

    // Number of registered halving stages that take a BITS-wide accumulator down to DIGEST.
    function automatic int unsigned fold_stages(input int unsigned bits,
                                                input int unsigned digest);
        return $clog2(bits / digest);
    endfunction

    function automatic int unsigned frame_width(input int unsigned channels,
                                                input int unsigned digest);
        return channels * digest;
    endfunction

    typedef enum logic {FastIdle, FastWait} fast_state_e;
    typedef enum logic {SlowIdle, SlowShift} slow_state_e;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a single toggle level crossing into clk_i.
module toggle_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/output_harness_multi.sv
// Compresses CHANNELS input buses into XOR digests and streams the signature word
// out serially in the slow_clk domain via a toggle req/ack handshake.
module output_harness_multi
    import output_harness_pkg::*;
#(
    parameter int unsigned BITS        = 64,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIGEST      = 8,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                     fast_clk,
    input  logic                     slow_clk,
    input  logic                     rst_n,
    input  logic [CHANNELS*BITS-1:0] data_on_fast_clk,
    input  logic [CHANNELS-1:0]      valid_on_fast_clk,
    output logic                     pin_on_slow_clk,
    output logic                     frame_on_slow_clk
);

    localparam int          L     = int'(fold_stages(BITS, DIGEST));
    localparam int unsigned FRAME = frame_width(CHANNELS, DIGEST);
    localparam int unsigned CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [CHANNELS*BITS-1:0] data_reg_q;
    logic [CHANNELS-1:0]      valid_reg_q;
    logic [FRAME-1:0]         sig;

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            data_reg_q  <= '0;
            valid_reg_q <= '0;
        end else begin
            data_reg_q  <= data_on_fast_clk;
            valid_reg_q <= valid_on_fast_clk;
        end
    end

    // Stage 0 is the accumulator; every later stage XORs the two halves of the one before.
    for (genvar s = 0; s <= L; s++) begin : g_fold
        localparam int unsigned W = BITS >> s;
        logic [CHANNELS-1:0][W-1:0] stage_q;

        if (s == 0) begin : g_acc
            always_ff @(posedge fast_clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (valid_reg_q[c]) begin
                            stage_q[c] <= stage_q[c] ^ data_reg_q[c*BITS +: BITS];
                        end
                    end
                end
            end
        end else begin : g_xor
            always_ff @(posedge fast_clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        stage_q[c] <= g_fold[s-1].stage_q[c][W-1:0]
                                    ^ g_fold[s-1].stage_q[c][2*W-1:W];
                    end
                end
            end
        end
    end

    assign sig = g_fold[L].stage_q;

    fast_state_e      fast_state_q, fast_state_d;
    logic             req_q, req_d;
    logic [FRAME-1:0] hold_q, hold_d;
    logic             ack_sync;

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            fast_state_q <= FastIdle;
            req_q        <= 1'b0;
            hold_q       <= '0;
        end else begin
            fast_state_q <= fast_state_d;
            req_q        <= req_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        fast_state_d = fast_state_q;
        req_d        = req_q;
        hold_d       = hold_q;
        case (fast_state_q)
            FastIdle: begin
                if (req_q == ack_sync) begin
                    hold_d       = sig;
                    req_d        = ~req_q;
                    fast_state_d = FastWait;
                end
            end
            FastWait: begin
                if (ack_sync == req_q) begin
                    fast_state_d = FastIdle;
                end
            end
            default: fast_state_d = FastIdle;
        endcase
    end

    slow_state_e      slow_state_q, slow_state_d;
    logic             req_sync;
    logic             req_seen_q, req_seen_d;
    logic             ack_q, ack_d;
    logic [FRAME-1:0] shifter_q, shifter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk_i(slow_clk),
        .rst_n(rst_n),
        .d_i  (req_q),
        .q_o  (req_sync)
    );

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(fast_clk),
        .rst_n(rst_n),
        .d_i  (ack_q),
        .q_o  (ack_sync)
    );

    always_ff @(posedge slow_clk) begin
        if (!rst_n) begin
            slow_state_q <= SlowIdle;
            req_seen_q   <= 1'b0;
            ack_q        <= 1'b0;
            shifter_q    <= '0;
            cnt_q        <= '0;
        end else begin
            slow_state_q <= slow_state_d;
            req_seen_q   <= req_seen_d;
            ack_q        <= ack_d;
            shifter_q    <= shifter_d;
            cnt_q        <= cnt_d;
        end
    end

    // hold_q is a fast-domain register, safe to sample here because the fast side
    // keeps it frozen until our ack toggle has made its way back.
    always_comb begin
        slow_state_d      = slow_state_q;
        req_seen_d        = req_seen_q;
        ack_d             = ack_q;
        shifter_d         = shifter_q;
        cnt_d             = cnt_q;
        pin_on_slow_clk   = 1'b0;
        frame_on_slow_clk = 1'b0;
        case (slow_state_q)
            SlowIdle: begin
                if (req_sync != req_seen_q) begin
                    shifter_d    = hold_q;
                    req_seen_d   = req_sync;
                    ack_d        = ~ack_q;
                    cnt_d        = '0;
                    slow_state_d = SlowShift;
                end
            end
            SlowShift: begin
                pin_on_slow_clk   = shifter_q[0];
                frame_on_slow_clk = (cnt_q == '0);
                shifter_d         = shifter_q >> 1;
                if (cnt_q == CNT_W'(FRAME - 1)) begin
                    slow_state_d = SlowIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: slow_state_d = SlowIdle;
        endcase
    end

endmodule

// File: tb/tb_output_harness_multi.sv
// Directed bench for output_harness_multi: a 2x8-bit/4-bit-digest instance (a) and a
// 1x8-bit unfolded instance (b), fast:slow clock ratio 7:1.
module tb_output_harness_multi;

    logic        fast_clk = 1'b0;
    logic        slow_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] data_a   = '0;
    logic [1:0]  valid_a  = '0;
    logic [7:0]  data_b   = '0;
    logic        valid_b  = 1'b0;
    logic        pin_a, frame_a, pin_b, frame_b;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 fast_clk = ~fast_clk;
    initial begin
        #3;
        forever #35 slow_clk = ~slow_clk;
    end

    output_harness_multi #(
        .BITS(8), .CHANNELS(2), .DIGEST(4), .SYNC_STAGES(3)
    ) dut_a (
        .fast_clk         (fast_clk),
        .slow_clk         (slow_clk),
        .rst_n            (rst_n),
        .data_on_fast_clk (data_a),
        .valid_on_fast_clk(valid_a),
        .pin_on_slow_clk  (pin_a),
        .frame_on_slow_clk(frame_a)
    );

    output_harness_multi #(
        .BITS(8), .CHANNELS(1), .DIGEST(8), .SYNC_STAGES(3)
    ) dut_b (
        .fast_clk         (fast_clk),
        .slow_clk         (slow_clk),
        .rst_n            (rst_n),
        .data_on_fast_clk (data_b),
        .valid_on_fast_clk(valid_b),
        .pin_on_slow_clk  (pin_b),
        .frame_on_slow_clk(frame_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signature of instance a: two 8-bit channels folded to 4 bits each.
    function automatic logic [7:0] fold_a(input logic [15:0] x);
        return {x[15:12] ^ x[11:8], x[7:4] ^ x[3:0]};
    endfunction

    task automatic drive(input logic [15:0] da, input logic [1:0] va,
                         input logic [7:0] db, input logic vb);
        @(negedge fast_clk);
        data_a  = da;
        valid_a = va;
        data_b  = db;
        valid_b = vb;
    endtask

    // Waits for the next frame marker and collects 8 bits, sampled on slow negedges.
    task automatic read_frame(input string tag, input bit sel_b,
                              output logic [7:0] bits, output logic [7:0] frms);
        int n;
        n    = 0;
        bits = '0;
        frms = '0;
        do begin
            @(negedge slow_clk);
            n++;
        end while (((sel_b ? frame_b : frame_a) !== 1'b1) && n < 60);
        check({tag, "_arrived"}, (sel_b ? frame_b : frame_a), 1'b1);
        if (n < 60) begin
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge slow_clk);
                bits[i] = sel_b ? pin_b : pin_a;
                frms[i] = sel_b ? frame_b : frame_a;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bits, frms;
        bit          pins_a [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit          pins_b [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        logic [15:0] cum [1000];
        logic [7:0]  exp_q [$];
        logic [7:0]  rx_q [$];
        logic [15:0] stim;
        logic [1:0]  sv;
        logic        prev_req;
        bit          rx_done;
        int          t4_i;
        int          n;

        // Reset state
        repeat (6) @(negedge slow_clk);
        check("rst_pin_a", pin_a, 1'b0);
        check("rst_frame_a", frame_a, 1'b0);
        check("rst_pin_b", pin_b, 1'b0);
        check("rst_frame_b", frame_b, 1'b0);
        rst_n = 1'b1;

        // Data present but never valid: signature stays zero
        drive(16'h00FF, 2'b00, 8'hFF, 1'b0);
        repeat (100) @(negedge fast_clk);
        for (int k = 0; k < 2; k++) begin
            read_frame("quiet_a", 1'b0, bits, frms);
            check("quiet_a_sig", bits, 8'h00);
        end

        // One valid beat on every channel
        drive(16'h300F, 2'b11, 8'hA5, 1'b1);
        drive(16'h0000, 2'b00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) read_frame("beat_a", 1'b0, bits, frms);
        check("beat_a_sig", bits, 8'h3F);
        for (int i = 0; i < 8; i++) check($sformatf("beat_a_pin%0d", i), bits[i], pins_a[i]);
        check("beat_a_marker", frms, 8'h01);
        for (int k = 0; k < 3; k++) read_frame("beat_b", 1'b1, bits, frms);
        check("beat_b_sig", bits, 8'hA5);
        for (int i = 0; i < 8; i++) check($sformatf("beat_b_pin%0d", i), bits[i], pins_b[i]);
        check("beat_b_marker", frms, 8'h01);

        // Reset in the middle of a 0x3F frame, at bit 3
        n = 0;
        do begin
            @(negedge slow_clk);
            n++;
        end while (frame_a !== 1'b1 && n < 60);
        check("midrst_frame_seen", frame_a, 1'b1);
        repeat (3) @(negedge slow_clk);
        check("midrst_pin3", pin_a, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge slow_clk);
            check($sformatf("midrst_pin_c%0d", i), pin_a, 1'b0);
            check($sformatf("midrst_frame_c%0d", i), frame_a, 1'b0);
        end
        rst_n = 1'b1;
        read_frame("post_rst", 1'b0, bits, frms);
        check("post_rst_sig", bits, 8'h00);
        check("post_rst_marker", frms, 8'h01);

        // Same value twice on ch0 cancels; only 0x00 or the one-cycle 0x0F may ever show
        drive(16'h000F, 2'b01, 8'h00, 1'b0);
        drive(16'h000F, 2'b01, 8'h00, 1'b0);
        drive(16'h0000, 2'b00, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            read_frame("cancel", 1'b0, bits, frms);
            check($sformatf("cancel_legal%0d", k), (bits == 8'h00 || bits == 8'h0F), 1'b1);
            check($sformatf("cancel_marker%0d", k), frms, 8'h01);
            if (k >= 2) check($sformatf("cancel_settled%0d", k), bits, 8'h00);
        end

        // Input changes every fast cycle; each frame must equal the model sig at its capture
        @(negedge slow_clk);
        rst_n = 1'b0;
        repeat (6) @(negedge slow_clk);
        @(negedge fast_clk);
        rst_n    = 1'b1;
        prev_req = 1'b0;
        rx_done  = 1'b0;
        t4_i     = 0;
        fork
            begin
                while (!rx_done && t4_i < 1000) begin
                    @(negedge fast_clk);
                    // A req toggle seen now means capture at the previous posedge,
                    // which latched the fold of everything driven up to t4_i-4.
                    if (dut_a.req_q !== prev_req) begin
                        exp_q.push_back(t4_i >= 4 ? fold_a(cum[t4_i-4]) : 8'h00);
                        prev_req = dut_a.req_q;
                    end
                    stim    = {8'(t4_i * 51 + 7), 8'(t4_i * 29) ^ 8'h5A};
                    sv      = 2'(t4_i * 3);
                    data_a  = stim;
                    valid_a = sv;
                    cum[t4_i] = (t4_i > 0 ? cum[t4_i-1] : 16'h0000)
                              ^ {sv[1] ? stim[15:8] : 8'h00, sv[0] ? stim[7:0] : 8'h00};
                    t4_i++;
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    read_frame("stream", 1'b0, bits, frms);
                    rx_q.push_back(bits);
                    check($sformatf("stream_marker%0d", k), frms, 8'h01);
                end
                rx_done = 1'b1;
            end
        join
        drive(16'h0000, 2'b00, 8'h00, 1'b0);
        check("stream_budget", (t4_i < 1000), 1'b1);
        check("stream_captures", (exp_q.size() >= 6), 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k < exp_q.size()) check($sformatf("stream_sig%0d", k), rx_q[k], exp_q[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
